// File: rtl/uart_dump_ctrl_if.sv
// uart_dump_ctrl_if: bus bundle between the dump controller, the capture RAM
// and the shared uart_tx.
//   mem_addr/mem_rd   controller -> RAM  read address and strobe
//   mem_rdata         RAM -> controller  read data, sampled in the cycle after
//                                        the controller decides to read
//   uart_wreq/wdata   controller -> uart_tx  one-cycle byte write
//   uart_rdy          uart_tx -> controller  transmitter idle
// master = controller side, slave = RAM/uart_tx side.
interface uart_dump_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              uart_wreq;
  logic [7:0]        uart_wdata;
  logic              uart_rdy;

  modport master (output mem_addr, mem_rd, uart_wreq, uart_wdata,
                  input  mem_rdata, uart_rdy);
  modport slave  (input  mem_addr, mem_rd, uart_wreq, uart_wdata,
                  output mem_rdata, uart_rdy);
endinterface

// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl: drains the capture buffer through uart_tx as a framed packet
//   SYNC0, SYNC1, L[15:8], L[7:0], payload[0..L-1] [, checksum]
// where L = min(len, DEPTH). Byte pacing follows uart_rdy only: each byte waits
// for rdy, pulses wreq, then waits for rdy to fall and rise again.
// Ports:
//   clk_50M, nrst     clock, async active-low reset
//   start, abort, len frame control (abort wins over everything)
//   busy, done        frame in progress / one-cycle end-of-frame pulse
//   sent_cnt          payload bytes handed to uart_tx in this/last frame
//   bus               uart_dump_ctrl_if.master (RAM read + uart_tx write)
// Build option: define DUMP_CHECKSUM_EN to append the modulo-256 payload sum.
module uart_dump_ctrl #(
  parameter int                N_data = 8,
  parameter int                DEPTH  = 4096,
  parameter int                ADDR_W = 12,
  parameter logic [N_data-1:0] SYNC0  = 8'hA5,
  parameter logic [N_data-1:0] SYNC1  = 8'h5A
) (
  input  logic        clk_50M,
  input  logic        nrst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [15:0] sent_cnt,
  uart_dump_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, SEL, FETCH, ISSUE, WAIT_LO, WAIT_HI, FIN} state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state;
  logic [16:0] idx;      // frame byte index; 17 bits so L+4 never wraps
  logic [15:0] len_l;    // clamped length L
  logic        is_pl;    // byte currently in flight is payload
  logic [16:0] pl_end;   // first index past the payload
  logic [16:0] n_bytes;  // total frame length
  logic [16:0] idx_nx;

  assign pl_end = {1'b0, len_l} + 17'd4;
  assign idx_nx = idx + 17'd1;

`ifdef DUMP_CHECKSUM_EN
  logic [N_data-1:0] csum;
  assign n_bytes = pl_end + 17'd1;
`else
  assign n_bytes = pl_end;
`endif

  always_ff @(posedge clk_50M or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      idx            <= '0;
      len_l          <= '0;
      is_pl          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sent_cnt       <= '0;
      bus.mem_addr   <= '0;
      bus.mem_rd     <= 1'b0;
      bus.uart_wreq  <= 1'b0;
      bus.uart_wdata <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      // strobes default low so each is a single-cycle pulse
      bus.uart_wreq <= 1'b0;
      bus.mem_rd    <= 1'b0;
      done          <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            len_l    <= (len > DEPTH16) ? DEPTH16 : len;
            sent_cnt <= '0;
            idx      <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
            busy     <= 1'b1;
            state    <= SEL;
          end
          SEL: begin
            is_pl <= 1'b0;
            state <= ISSUE;
            if (idx >= n_bytes) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              case (idx)
                17'd0:   bus.uart_wdata <= SYNC0;
                17'd1:   bus.uart_wdata <= SYNC1;
                17'd2:   bus.uart_wdata <= len_l[15:8];
                17'd3:   bus.uart_wdata <= len_l[7:0];
                default: begin
                  if (idx < pl_end) begin
                    bus.mem_addr <= ADDR_W'(idx - 17'd4);
                    bus.mem_rd   <= 1'b1;
                    is_pl        <= 1'b1;
                    state        <= FETCH;
                  end
`ifdef DUMP_CHECKSUM_EN
                  else bus.uart_wdata <= csum;
`endif
                end
              endcase
            end
          end
          FETCH: begin
            bus.uart_wdata <= bus.mem_rdata;
`ifdef DUMP_CHECKSUM_EN
            csum           <= csum + bus.mem_rdata;
`endif
            state          <= ISSUE;
          end
          ISSUE: if (bus.uart_rdy) begin
            bus.uart_wreq <= 1'b1;
            if (is_pl) sent_cnt <= sent_cnt + 16'd1;
            state <= WAIT_LO;
          end
          WAIT_LO: if (!bus.uart_rdy) state <= WAIT_HI;
          WAIT_HI: if (bus.uart_rdy) begin
            idx <= idx_nx;
            // finish straight from here so done lands one cycle after WAIT_HI
            if (idx_nx >= n_bytes) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= SEL;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Randomized bench for uart_dump_ctrl: behavioural RAM, a uart_tx model whose
// busy time is fixed or random per byte, and a frame model built from the
// packet format (header, clamped length, payload, optional sum).
module tb_uart_dump_ctrl;
  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;

  logic        clk_50M = 1'b0;
  logic        nrst    = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [15:0] len     = '0;
  logic        busy, done;
  logic [15:0] sent_cnt;

  uart_dump_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_dump_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_50M (clk_50M),
    .nrst    (nrst),
    .start   (start),
    .abort   (abort),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .sent_cnt(sent_cnt),
    .bus     (bus)
  );

  always #10 clk_50M = ~clk_50M;

  logic [7:0] mem [DEPTH];
  assign bus.mem_rdata = mem[bus.mem_addr];

  int checks = 0, failures = 0;
  logic [7:0] got [$];
  logic [7:0] exp [$];
  int wreq_n = 0, rd_n = 0, done_n = 0, last_addr = -1, tx_cnt = 0, tx_lat = 1;

  // uart_tx model: rdy drops after a write and returns after tx_lat cycles
  // (tx_lat == 0 picks a random 1..4 per byte); plus event counters.
  always @(negedge clk_50M) begin
    if (bus.uart_wreq) begin
      got.push_back(bus.uart_wdata);
      wreq_n++;
      tx_cnt = (tx_lat == 0) ? int'($urandom_range(1, 4)) : tx_lat;
      bus.uart_rdy = 1'b0;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) bus.uart_rdy = 1'b1;
    end
    if (bus.mem_rd) begin rd_n++; last_addr = int'(bus.mem_addr); end
    if (done) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int clamp_len(input int n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  function automatic void build_exp(input int n);
    logic [15:0] l16;
    logic [7:0]  s;
    l16 = 16'(clamp_len(n));
    s   = 8'h00;
    exp.delete();
    exp.push_back(8'hA5);
    exp.push_back(8'h5A);
    exp.push_back(l16[15:8]);
    exp.push_back(l16[7:0]);
    for (int i = 0; i < int'(l16); i++) begin
      exp.push_back(mem[i]);
      s = s + mem[i];
    end
`ifdef DUMP_CHECKSUM_EN
    exp.push_back(s);
`endif
  endfunction

  task automatic clr_cnt();
    got.delete();
    wreq_n = 0; rd_n = 0; done_n = 0; last_addr = -1;
  endtask

  task automatic start_frame(input int n);
    clr_cnt();
    @(negedge clk_50M);
    len = 16'(n); start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_n == 0 && k < 60000) begin @(negedge clk_50M); k++; end
    chk({tag, "_done_seen"}, 32'(done_n > 0), 32'd1);
    repeat (3) @(negedge clk_50M);
  endtask

  task automatic wait_sent(input int n);
    int k;
    k = 0;
    while (sent_cnt != 16'(n) && k < 5000) begin @(negedge clk_50M); k++; end
    chk("wait_sent_cnt", 32'(sent_cnt), 32'(n));
  endtask

  task automatic check_frame(input string tag, input int n);
    int nbad;
    build_exp(n);
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp.size()));
    chk({tag, "_wreq_n"}, 32'(wreq_n), 32'(exp.size()));
    nbad = 0;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      if (exp.size() <= 64) chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
      else if (got[i] !== exp[i]) nbad++;
    end
    if (exp.size() > 64) chk({tag, "_bad_bytes"}, 32'(nbad), 32'd0);
    chk({tag, "_done_n"}, 32'(done_n), 32'd1);
    chk({tag, "_sent_cnt"}, 32'(sent_cnt), 32'(clamp_len(n)));
    chk({tag, "_rd_n"}, 32'(rd_n), 32'(clamp_len(n)));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wreq"},  32'(bus.uart_wreq),  32'd0);
    chk({tag, "_wdata"}, 32'(bus.uart_wdata), 32'd0);
    chk({tag, "_rd"},    32'(bus.mem_rd),     32'd0);
    chk({tag, "_addr"},  32'(bus.mem_addr),   32'd0);
    chk({tag, "_busy"},  32'(busy),           32'd0);
    chk({tag, "_done"},  32'(done),           32'd0);
    chk({tag, "_sent"},  32'(sent_cnt),       32'd0);
  endtask

  initial begin
    int n, k, w0;
    bus.uart_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    #25;
    chk_reset_vals("rst");
    @(negedge clk_50M);
    nrst = 1'b1;
    repeat (2) @(negedge clk_50M);

    // directed: 01..04, slow transmitter, plus start-to-first-wreq latency
    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    tx_lat = 20;
    clr_cnt();
    len = 16'd4; start = 1'b1;
    @(posedge clk_50M);               // edge 0
    @(negedge clk_50M); start = 1'b0;
    chk("lat_busy_e0", 32'(busy), 32'd1);
    chk("lat_wreq_e0", 32'(bus.uart_wreq), 32'd0);
    @(negedge clk_50M);
    chk("lat_wreq_e1", 32'(bus.uart_wreq), 32'd0);
    @(negedge clk_50M);
    chk("lat_wreq_e2", 32'(bus.uart_wreq), 32'd1);
    wait_done("f4");
    check_frame("f4", 4);

    // empty frame
    tx_lat = 0;
    start_frame(0);
    wait_done("f0");
    check_frame("f0", 0);

    // random frames
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      n = int'($urandom_range(1, 40));
      start_frame(n);
      wait_done($sformatf("rnd%0d", r));
      check_frame($sformatf("rnd%0d", r), n);
    end

    // oversize length is clamped to the buffer depth
    tx_lat = 1;
    start_frame(5000);
    wait_done("big");
    check_frame("big", 5000);
    chk("big_last_addr", 32'(last_addr), 32'(DEPTH - 1));

    // abort in the third payload byte's WAIT_LO
    tx_lat = 3;
    start_frame(8);
    wait_sent(3);
    abort = 1'b1;
    @(negedge clk_50M); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    w0 = wreq_n;
    repeat (100) @(negedge clk_50M);
    chk("abort_wreq_n", 32'(wreq_n), 32'(w0));
    chk("abort_nbytes", 32'(got.size()), 32'd7);
    chk("abort_done_n", 32'(done_n), 32'd0);
    chk("abort_sent", 32'(sent_cnt), 32'd3);

    // start mid-frame is ignored
    tx_lat = 0;
    start_frame(6);
    wait_sent(1);
    len = 16'd2; start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    wait_done("restart");
    check_frame("restart", 6);

    // start together with abort in IDLE is ignored
    clr_cnt();
    len = 16'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk_50M); start = 1'b0; abort = 1'b0;
    repeat (10) @(negedge clk_50M);
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_wreq_n", 32'(wreq_n), 32'd0);

    // reset mid-payload, then a fresh frame
    start_frame(10);
    wait_sent(2);
    nrst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk_50M); nrst = 1'b1;
    k = 0;
    while (!bus.uart_rdy && k < 100) begin @(negedge clk_50M); k++; end
    chk("midrst_rdy_back", 32'(bus.uart_rdy), 32'd1);
    start_frame(3);
    wait_done("post_rst");
    check_frame("post_rst", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
